etroc_afc_ctrl: RTL and testbench
=================================

ETROC_AFC_CTRL -- requirements
Module: etroc_afc_ctrl

Interface
REQ-001 Parameter CAP_W, default 6, width of the VCO capacitor-bank code.
REQ-002 Parameter CNT_W, default 12, width of the tick counter and of the target.
REQ-003 Parameter WIN_LOG2, default 8, measurement window of 2^WIN_LOG2 clock cycles.
REQ-004 Parameter SETTLE, default 16, settle cycles after each code change, minimum 1.
REQ-005 Parameter TOL, default 2, tracking dead band in ticks.
REQ-006 CLK40REF  in  1  sole clock, 40 MHz reference; all logic on its rising edge.
REQ-007 toAFC_RST  in  1  reset, asynchronous, active-high.
REQ-008 toAFC_Start  in  1  level; a rising edge launches calibration.
REQ-009 toAFC_Mode  in  1  0 = single binary search; 1 = binary search followed by continuous tracking.
REQ-010 toAFC_OverrideCtrl  in  1  1 = bypass calibration and drive the override code.
REQ-011 toAFC_OverrideCtrl_val  in  CAP_W  override capacitor code.
REQ-012 toAFC_Target  in  CNT_W  expected tick count per window.
REQ-013 vcoTick  in  1  one-cycle pulse per divided-VCO period, already synchronous to CLK40REF.
REQ-014 toI2C_AFCcalCap  out  CAP_W  capacitor code applied to the VCO.
REQ-015 toI2C_AFCbusy  out  1  high while the binary search runs.
REQ-016 afcDone  out  1  high once a search has completed, until the next start or abort.
REQ-017 afcLastCount  out  CNT_W  tick count of the most recent completed window.

Function
REQ-018 The FSM SHALL have states IDLE, SETTLE, MEASURE, DECIDE and DONE.
REQ-019 Start edge SHALL equal start AND NOT start_q (registered); SETTLE SHALL be entered on the clock after the edge is detected, with busy high in that same cycle.
REQ-020 On search entry, the code SHALL be cleared, the bit index SHALL be set to CAP_W-1, and the trial code SHALL equal 1 << (CAP_W-1).
REQ-021 SETTLE SHALL last exactly SETTLE cycles, then enter MEASURE with the counter cleared.
REQ-022 MEASURE SHALL last exactly 2^WIN_LOG2 cycles; every cycle with vcoTick=1 increments the count, including the first and last cycles; the count SHALL saturate at 2^CNT_W-1.
REQ-023 DECIDE SHALL last 1 cycle; afcLastCount <= count; if count > target, the trial bit is kept, otherwise it is cleared (a tie clears it).
REQ-024 If DECIDE is not on bit 0, the next lower bit SHALL be set in the trial code and the FSM SHALL return to SETTLE; on bit 0 it SHALL go to DONE.
REQ-025 Search duration SHALL be CAP_W*(SETTLE+2^WIN_LOG2+1) cycles; with the defaults this is 1638.
REQ-026 On DONE entry, busy SHALL go low and afcDone SHALL go high.
REQ-027 With Mode=0, DONE SHALL hold the code.
REQ-028 With Mode=1, DONE SHALL repeat SETTLE/MEASURE cycles with busy low.
REQ-029 In Mode=1 tracking, after each window: if count > target+TOL, the code increments by 1, saturating at 2^CAP_W-1; if count+TOL < target, the code decrements by 1, saturating at 0; otherwise it is unchanged.
REQ-030 Tracking comparisons SHALL use CNT_W+1 bits so that no wrap occurs.
REQ-031 toI2C_AFCcalCap SHALL show the live trial/tracked code in every non-override state.
REQ-032 A start edge during search SHALL be ignored.
REQ-033 A start edge in DONE or IDLE SHALL restart the search and clear afcDone.
REQ-034 OverrideCtrl=1 SHALL force the FSM to IDLE from any state on the next clock, clear busy and afcDone, and make calCap equal the override value combinationally.
REQ-035 When override is released, calCap SHALL show the last held code, and the FSM SHALL stay in IDLE until a start edge.
REQ-036 If a start edge and OverrideCtrl=1 occur in the same cycle, override SHALL win and the start SHALL be discarded.
REQ-037 A Mode change SHALL be sampled only on DONE entry.

Reset
REQ-038 While toAFC_RST=1, the FSM SHALL be IDLE and calCap, busy, afcDone, afcLastCount, counters and start_q SHALL all be 0; override output muxing SHALL still apply during reset.
REQ-039 Reset asserted mid-search SHALL abort immediately, asynchronously, with no partial code retained.
REQ-040 After reset release, the block SHALL stay in IDLE until a fresh start edge; a start already high at release SHALL NOT trigger, because start_q is loaded on the first clock.

Verification
REQ-041 Defaults, Mode=0, vcoTick on every cycle (count 256), target=100 -> all bits kept, code 63, busy high for 1638 cycles, afcDone=1, afcLastCount=256.
REQ-042 Tick rate modelled as (64-code)*4 per window, target=128 -> converges to code 32; the tie at code 32 clears the bit; final code 32±1, matching a golden model.
REQ-043 Override=1, val=6'b111100, mid-search at cycle 500 -> next clock IDLE, busy=0, calCap=60; release -> calCap shows the held code, no activity until start.
REQ-044 Mode=1, converge, then shift the tick rate so count exceeds target+TOL -> code steps +1 per 273-cycle period, saturates at 63, busy stays 0.
REQ-045 CNT_W=4, continuous ticks -> count saturates at 15, no wrap, and the bit is kept when target<15.
REQ-046 Reset pulse at cycle 700 with start held high -> all outputs 0 at once, no restart after release until start toggles low then high.

Source files
------------

// File: rtl/etroc_afc_ctrl.sv
// ETROC VCO automatic frequency calibration: binary search of the capacitor
// bank against a tick-count target, optionally followed by dead-band tracking.
module etroc_afc_ctrl #(
    parameter int CAP_W    = 6,
    parameter int CNT_W    = 12,
    parameter int WIN_LOG2 = 8,
    parameter int SETTLE   = 16,
    parameter int TOL      = 2
) (
    input  logic             CLK40REF,
    input  logic             toAFC_RST,
    input  logic             toAFC_Start,
    input  logic             toAFC_Mode,
    input  logic             toAFC_OverrideCtrl,
    input  logic [CAP_W-1:0] toAFC_OverrideCtrl_val,
    input  logic [CNT_W-1:0] toAFC_Target,
    input  logic             vcoTick,
    output logic [CAP_W-1:0] toI2C_AFCcalCap,
    output logic             toI2C_AFCbusy,
    output logic             afcDone,
    output logic [CNT_W-1:0] afcLastCount
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int TMR_W = ((WIN_LOG2 > SET_W) ? WIN_LOG2 : SET_W) + 1;
    localparam int BIT_W = (CAP_W > 1) ? $clog2(CAP_W) : 1;

    localparam logic [TMR_W-1:0] TMR_ZERO    = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'((1 << WIN_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CAP_W-1:0] CAP_ZERO    = {CAP_W{1'b0}};
    localparam logic [CAP_W-1:0] CAP_MAX     = {CAP_W{1'b1}};
    localparam logic [CAP_W-1:0] CAP_MSB     = CAP_W'(1'b1) << (CAP_W - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO    = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_TOP     = BIT_W'(CAP_W - 1);
    localparam logic [CNT_W:0]   TOL_X       = (CNT_W + 1)'(TOL);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             start_q_r;
    logic             armed_r;
    logic             busy_r;
    logic             done_r;
    logic             track_r;
    logic [CAP_W-1:0] code_r;
    logic [BIT_W-1:0] bit_r;
    logic [TMR_W-1:0] tmr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] last_r;

    logic             start_edge_s;
    logic             launch_s;
    logic             keep_s;
    logic [CAP_W-1:0] code_nxt_s;
    logic [CNT_W:0]   cnt_x_s;
    logic [CNT_W:0]   tgt_x_s;
    logic             trk_up_s;
    logic             trk_dn_s;
    logic [CAP_W-1:0] trk_code_s;
    logic [CAP_W-1:0] cal_cap_s;

    // Start qualification: armed_r masks a start already high at reset release,
    // and a running search (busy) ignores further edges.
    always_comb begin
        start_edge_s = toAFC_Start & ~start_q_r & armed_r;
        launch_s     = start_edge_s & ~toAFC_OverrideCtrl & ~busy_r;
    end

    // Binary-search step: resolve the current trial bit, then arm the next one.
    always_comb begin
        keep_s             = (count_r > toAFC_Target);
        code_nxt_s         = code_r;
        code_nxt_s[bit_r]  = keep_s;
        if (bit_r != BIT_ZERO) begin
            code_nxt_s[bit_r - 1'b1] = 1'b1;
        end else begin
            code_nxt_s[0] = keep_s;
        end
    end

    // Tracking step, compared one bit wider so target+TOL cannot wrap.
    always_comb begin
        cnt_x_s  = {1'b0, count_r};
        tgt_x_s  = {1'b0, toAFC_Target};
        trk_up_s = (cnt_x_s > (tgt_x_s + TOL_X));
        trk_dn_s = ((cnt_x_s + TOL_X) < tgt_x_s);
        if (trk_up_s && (code_r != CAP_MAX)) begin
            trk_code_s = code_r + 1'b1;
        end else if (trk_dn_s && (code_r != CAP_ZERO)) begin
            trk_code_s = code_r - 1'b1;
        end else begin
            trk_code_s = code_r;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK40REF or posedge toAFC_RST) begin
        if (toAFC_RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; override beats everything, including a launch.
    always_comb begin
        state_nxt_s = state_r;
        if (toAFC_OverrideCtrl) begin
            state_nxt_s = ST_IDLE;
        end else if (launch_s) begin
            state_nxt_s = ST_SETTLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_nxt_s = ST_IDLE;
                ST_SETTLE:  state_nxt_s = (tmr_r == SETTLE_LAST) ? ST_MEASURE : ST_SETTLE;
                ST_MEASURE: state_nxt_s = (tmr_r == WIN_LAST) ? ST_DECIDE : ST_MEASURE;
                ST_DECIDE:  state_nxt_s = (busy_r && (bit_r == BIT_ZERO)) ? ST_DONE : ST_SETTLE;
                ST_DONE:    state_nxt_s = track_r ? ST_SETTLE : ST_DONE;
                default:    state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Datapath: timers, tick counter, trial/tracked code and status flags.
    always_ff @(posedge CLK40REF or posedge toAFC_RST) begin
        if (toAFC_RST) begin
            start_q_r <= 1'b0;
            armed_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            track_r   <= 1'b0;
            code_r    <= CAP_ZERO;
            bit_r     <= BIT_ZERO;
            tmr_r     <= TMR_ZERO;
            count_r   <= CNT_ZERO;
            last_r    <= CNT_ZERO;
        end else begin
            start_q_r <= toAFC_Start;
            armed_r   <= 1'b1;
            if (toAFC_OverrideCtrl) begin
                busy_r  <= 1'b0;
                done_r  <= 1'b0;
                track_r <= 1'b0;
                tmr_r   <= TMR_ZERO;
            end else if (launch_s) begin
                code_r  <= CAP_MSB;
                bit_r   <= BIT_TOP;
                busy_r  <= 1'b1;
                done_r  <= 1'b0;
                track_r <= 1'b0;
                tmr_r   <= TMR_ZERO;
            end else begin
                case (state_r)
                    ST_SETTLE: begin
                        if (tmr_r == SETTLE_LAST) begin
                            tmr_r   <= TMR_ZERO;
                            count_r <= CNT_ZERO;
                        end else begin
                            tmr_r <= tmr_r + 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        if (vcoTick && (count_r != CNT_MAX)) begin
                            count_r <= count_r + 1'b1;
                        end else begin
                            count_r <= count_r;
                        end
                        if (tmr_r == WIN_LAST) begin
                            tmr_r <= TMR_ZERO;
                        end else begin
                            tmr_r <= tmr_r + 1'b1;
                        end
                    end
                    ST_DECIDE: begin
                        last_r <= count_r;
                        tmr_r  <= TMR_ZERO;
                        if (busy_r) begin
                            code_r <= code_nxt_s;
                            if (bit_r == BIT_ZERO) begin
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                track_r <= toAFC_Mode;
                            end else begin
                                bit_r <= bit_r - 1'b1;
                            end
                        end else begin
                            code_r <= trk_code_s;
                        end
                    end
                    default: begin
                        tmr_r <= tmr_r;
                    end
                endcase
            end
        end
    end

    // Output mux: override is applied combinationally, even during reset.
    always_comb begin
        if (toAFC_OverrideCtrl) begin
            cal_cap_s = toAFC_OverrideCtrl_val;
        end else begin
            cal_cap_s = code_r;
        end
    end

    assign toI2C_AFCcalCap = cal_cap_s;
    assign toI2C_AFCbusy   = busy_r;
    assign afcDone         = done_r;
    assign afcLastCount    = last_r;

endmodule

// File: tb/tb_etroc_afc_ctrl.sv
// Bench for etroc_afc_ctrl: closed-loop VCO tick model, scoreboarded searches,
// override/reset/tracking scenarios, and a narrow-counter instance.
module tb_etroc_afc_ctrl;

    localparam int SEARCH = 1638;
    localparam int PERIOD = 273;

    logic        clk = 1'b0;
    logic        rst, start, mode, ovr, tick;
    logic [5:0]  ovr_val, cal;
    logic [11:0] target, last;
    logic        busy, done;

    logic        start4, mode4, ovr4, tick4, busy4, done4;
    logic [5:0]  ovr_val4, cal4;
    logic [3:0]  target4, last4;

    always #5 clk = ~clk;

    etroc_afc_ctrl dut (
        .CLK40REF(clk), .toAFC_RST(rst), .toAFC_Start(start), .toAFC_Mode(mode),
        .toAFC_OverrideCtrl(ovr), .toAFC_OverrideCtrl_val(ovr_val), .toAFC_Target(target),
        .vcoTick(tick), .toI2C_AFCcalCap(cal), .toI2C_AFCbusy(busy), .afcDone(done),
        .afcLastCount(last)
    );

    etroc_afc_ctrl #(.CAP_W(6), .CNT_W(4), .WIN_LOG2(5), .SETTLE(1), .TOL(2)) dut4 (
        .CLK40REF(clk), .toAFC_RST(rst), .toAFC_Start(start4), .toAFC_Mode(mode4),
        .toAFC_OverrideCtrl(ovr4), .toAFC_OverrideCtrl_val(ovr_val4), .toAFC_Target(target4),
        .vcoTick(tick4), .toI2C_AFCcalCap(cal4), .toI2C_AFCbusy(busy4), .afcDone(done4),
        .afcLastCount(last4)
    );

    typedef struct {
        int code;
        int last;
        int bcyc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ra = 256;
    int   rb = 0;

    // VCO model: ticks per 256-cycle window as a clipped linear function of the code.
    function automatic int rate(input int code);
        int r;
        r = ra - rb * code;
        if (r < 0) r = 0;
        if (r > 256) r = 256;
        return r;
    endfunction

    // Reference search: trial each bit from MSB, keep it only when count > target.
    function automatic int partial(input int tgt, input int nbits);
        int code;
        code = 0;
        for (int b = 5; b > 5 - nbits; b--) begin
            if (rate(code | (1 << b)) > tgt) code = code | (1 << b);
        end
        if (nbits < 6) code = code | (1 << (5 - nbits));
        return code;
    endfunction

    function automatic exp_t golden(input int tgt);
        exp_t e;
        int   code, cnt, trial;
        code = 0;
        cnt  = 0;
        for (int b = 5; b >= 0; b--) begin
            trial = code | (1 << b);
            cnt   = rate(trial);
            if (cnt > 4095) cnt = 4095;
            if (cnt > tgt) code = trial;
        end
        e.code = code;
        e.last = cnt;
        e.bcyc = SEARCH;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input bit push, input int tgt);
        target = tgt[11:0];
        start  = 1'b0;
        cyc(1);
        start = 1'b1;
        if (push) sbq.push_back(golden(tgt));
        cyc(1);
        check("launch_busy", busy, 1);
        check("launch_done_clr", done, 0);
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while (sbq.size() != 0 && t < budget) begin
            cyc(1);
            t++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d pending after %0d cycles", sbq.size(), budget);
            sbq.delete();
        end
    endtask

    // Tick generator: Bresenham spread gives exactly rate(code) ticks in any 256 cycles.
    initial begin
        int gc, k;
        gc   = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            k = rate(int'(cal));
            gc++;
            tick = (((gc + 1) * k) / 256) > ((gc * k) / 256);
        end
    end

    // Scoreboard monitor: pops an expectation each time afcDone rises.
    initial begin
        int   bcnt;
        logic pd, pb;
        exp_t e;
        bcnt = 0;
        pd   = 1'b0;
        pb   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (busy === 1'b1) bcnt = pb ? bcnt + 1 : 1;
            if (done === 1'b1 && pd !== 1'b1) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected_done: code %0d with no pending search", cal);
                end else begin
                    e = sbq.pop_front();
                    check("sb_code", cal, e.code);
                    check("sb_last_count", last, e.last);
                    check("sb_busy_cycles", bcnt, e.bcyc);
                end
            end
            pd = done;
            pb = busy;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t4, nb, n, prev, lastt, t, snap, held, busy_seen, c;
        rst = 1'b1; start = 1'b0; mode = 1'b0; ovr = 1'b0; ovr_val = 6'd0; target = 12'd0;
        start4 = 1'b0; mode4 = 1'b0; ovr4 = 1'b0; ovr_val4 = 6'd0; target4 = 4'd0; tick4 = 1'b1;
        cyc(3);
        check("rst_cal", cal, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_last", last, 0);
        check("rst_cal4", cal4, 0);
        ovr = 1'b1; ovr_val = 6'd42;
        #1;
        check("rst_override_mux", cal, 42);
        ovr = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(5);
        check("idle_after_rst", busy, 0);

        // Narrow counter: continuous ticks saturate at 15; a tie at 15 clears every bit.
        for (int i = 0; i < 2; i++) begin
            t4 = (i == 0) ? int'($urandom_range(0, 14)) : 15;
            target4 = t4[3:0];
            start4 = 1'b0;
            cyc(1);
            start4 = 1'b1;
            cyc(1);
            nb = 0;
            n  = 0;
            while (done4 !== 1'b1 && n < 1000) begin
                if (busy4 === 1'b1) nb++;
                cyc(1);
                n++;
            end
            check("cnt4_done", done4, 1);
            check("cnt4_code", cal4, (t4 < 15) ? 63 : 0);
            check("cnt4_last_sat", last4, 15);
            check("cnt4_busy_cycles", nb, 6 * (1 + 32 + 1));
        end

        // Every tick counted: all bits kept.
        ra = 256; rb = 0;
        launch(1'b1, 100);
        wait_drain(3000);

        // Linear VCO converging near 32, with a start toggle mid-search that must be ignored.
        ra = 256; rb = 4;
        launch(1'b1, 128);
        cyc(700);
        start = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(1);
        check("start_ignored_busy", busy, 1);
        wait_drain(3000);

        for (int i = 0; i < 5; i++) begin
            ra = int'($urandom_range(64, 256));
            rb = int'($urandom_range(0, 4));
            launch(1'b1, int'($urandom_range(0, 300)));
            wait_drain(3000);
        end

        // Override mid-search.
        ra = 256; rb = 4;
        launch(1'b0, 128);
        cyc(497);
        held = partial(128, 1);
        ovr = 1'b1; ovr_val = 6'b111100;
        #1;
        check("ovr_comb_cal", cal, 60);
        cyc(1);
        check("ovr_busy", busy, 0);
        check("ovr_done", done, 0);
        cyc(20);
        check("ovr_hold_busy", busy, 0);
        ovr = 1'b0;
        #1;
        check("ovr_release_cal", cal, held);
        cyc(300);
        check("ovr_idle_cal", cal, held);
        check("ovr_idle_busy", busy, 0);

        // Start edge coincident with override is discarded.
        start = 1'b0;
        cyc(1);
        ovr = 1'b1; start = 1'b1;
        cyc(1);
        ovr = 1'b0;
        cyc(50);
        check("ovr_start_discard", busy, 0);
        check("ovr_start_cal", cal, held);

        // Asynchronous reset mid-search with start held high.
        launch(1'b0, 128);
        cyc(698);
        #2 rst = 1'b1;
        #1;
        check("arst_cal", cal, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_last", last, 0);
        cyc(3);
        rst = 1'b0;
        cyc(60);
        check("arst_no_restart", busy, 0);
        check("arst_cal_idle", cal, 0);
        launch(1'b1, 128);
        wait_drain(3000);

        // Tracking: converge, then drive counts above target+TOL.
        ra = 256; rb = 4; mode = 1'b1;
        launch(1'b1, 128);
        wait_drain(3000);
        mode = 1'b0;
        ra = 256; rb = 0;
        prev = int'(cal); lastt = -1; t = 0; busy_seen = 0;
        while (cal != 6'd63 && t < 12000) begin
            cyc(1);
            t++;
            if (busy === 1'b1) busy_seen = 1;
            if (int'(cal) != prev) begin
                check("trk_step", cal, prev + 1);
                if (lastt >= 0) check("trk_period", t - lastt, PERIOD);
                lastt = t;
                prev  = int'(cal);
            end
        end
        check("trk_reach_max", cal, 63);
        cyc(600);
        check("trk_sat_hold", cal, 63);
        check("trk_busy_low", busy_seen | int'(busy), 0);

        ra = 125;
        cyc(5 * PERIOD);
        c = int'(cal);
        check("trk_decrement", (c >= 58 && c <= 59) ? 1 : 0, 1);
        ra = 130;
        cyc(2 * PERIOD);
        snap = int'(cal);
        cyc(3 * PERIOD);
        check("trk_deadband_hi", cal, snap);
        ra = 126;
        cyc(2 * PERIOD);
        snap = int'(cal);
        cyc(3 * PERIOD);
        check("trk_deadband_lo", cal, snap);
        ra = 131;
        snap = int'(cal);
        cyc(3 * PERIOD + 10);
        check("trk_up_past_band", (int'(cal) >= snap + 2) ? 1 : 0, 1);

        // Restart from tracking in single-search mode, then the code must hold.
        ra = 256; rb = 4;
        launch(1'b1, 128);
        wait_drain(3000);
        cyc(600);
        check("mode0_hold", cal, golden(128).code);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
